// File: rtl/usb_pkg.sv
// Shared line-state and receiver-state types for the USB serial engine.
// Also holds the {dp, dm} decode helper and the EOP length constant.
package usb_pkg;

  typedef enum logic [1:0] {
    J,
    K,
    SE0,
    SE1
  } line_state_t;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    ACTIVE,
    EOP,
    DONE
  } rx_state_t;

  localparam int         EOP_SE0_BITS = 2;
  localparam logic [1:0] LINE_J_BITS  = 2'b10;

  function automatic line_state_t decode_line(input logic [1:0] dpdm);
    case (dpdm)
      2'b10:   decode_line = J;
      2'b01:   decode_line = K;
      2'b00:   decode_line = SE0;
      default: decode_line = SE1;
    endcase
  endfunction

endpackage

// File: rtl/usb_line_sampler.sv
// Two-stage DP/DM pipeline: sync_q feeds the framing FSM, hold_q drives stream_in.
// Latency 2 cycles from wire to stream_in; no backpressure, samples every edge.
module usb_line_sampler
  import usb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_L,
  input  logic       dp_in,
  input  logic       dm_in,
  output logic [1:0] sync_ls,
  output logic       stream_in
);

  logic [1:0] sync_q, sync_d;
  logic [1:0] hold_q, hold_d;

  always_comb begin
    sync_d = {dp_in, dm_in};
    hold_d = sync_q;
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      sync_q <= LINE_J_BITS;
      hold_q <= LINE_J_BITS;
    end else begin
      sync_q <= sync_d;
      hold_q <= hold_d;
    end
  end

  assign sync_ls   = decode_line(sync_q);
  // The sync stage runs one bit ahead of hold, so the FSM frames each bit before it leaves.
  assign stream_in = (decode_line(hold_q) == J);

endmodule

// File: rtl/usb_line_rcv.sv
// USB receive line front end: SOP detect, framing strobes, EOP/SE1/runaway checks.
// Latency 2 cycles wire to stream_in; no backpressure, status held until ack.
module usb_line_rcv
  import usb_pkg::*;
#(
  parameter int MAX_BITS = 128
) (
  input  logic clk,
  input  logic rst_L,
  input  logic dp_in,
  input  logic dm_in,
  input  logic sending,
  input  logic ack,
  output logic stream_in,
  output logic rcv_valid,
  output logic rcv_start,
  output logic rcv_last,
  output logic pkt_done,
  output logic EOP_ok,
  output logic line_err
);

  localparam int CW = $clog2(MAX_BITS + 1);

  logic [1:0]    sync_ls;
  line_state_t   sync_st;
  rx_state_t     state_q, state_d;
  logic [CW-1:0] bitcnt_q, bitcnt_d;
  logic [1:0]    se0cnt_q, se0cnt_d;
  logic          rcv_valid_q, rcv_valid_d;
  logic          rcv_start_q, rcv_start_d;
  logic          pkt_done_q, pkt_done_d;
  logic          eop_ok_q, eop_ok_d;
  logic          line_err_q, line_err_d;
  logic          eop_good;

  usb_line_sampler u_sampler (
    .clk      (clk),
    .rst_L    (rst_L),
    .dp_in    (dp_in),
    .dm_in    (dm_in),
    .sync_ls  (sync_ls),
    .stream_in(stream_in)
  );

  assign sync_st  = line_state_t'(sync_ls);
  assign eop_good = (sync_st == J) && (se0cnt_q == 2'(EOP_SE0_BITS));

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    se0cnt_d    = se0cnt_q;
    rcv_valid_d = 1'b0;
    rcv_start_d = 1'b0;
    pkt_done_d  = 1'b0;
    eop_ok_d    = eop_ok_q;
    line_err_d  = line_err_q;
    // Local transmit aborts reception silently; a finished packet still waits for ack.
    if (sending && (state_q != DONE)) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (sync_st == J) state_d = ARMED;
        end
        ARMED: begin
          if (sync_st == K) begin
            state_d     = ACTIVE;
            bitcnt_d    = CW'(1);
            rcv_valid_d = 1'b1;
            rcv_start_d = 1'b1;
          end
        end
        ACTIVE: begin
          case (sync_st)
            SE0: begin
              state_d  = EOP;
              se0cnt_d = 2'd1;
            end
            SE1: begin
              state_d    = DONE;
              line_err_d = 1'b1;
              pkt_done_d = 1'b1;
            end
            default: begin
              // A bit arriving with the counter already full is the first bit past the limit.
              if (bitcnt_q == CW'(MAX_BITS)) begin
                state_d    = DONE;
                line_err_d = 1'b1;
                pkt_done_d = 1'b1;
              end else begin
                bitcnt_d    = bitcnt_q + CW'(1);
                rcv_valid_d = 1'b1;
              end
            end
          endcase
        end
        EOP: begin
          if (sync_st == SE0) begin
            if (se0cnt_q != 2'd3) se0cnt_d = se0cnt_q + 2'd1;
          end else begin
            state_d    = DONE;
            eop_ok_d   = eop_good;
            line_err_d = !eop_good;
            pkt_done_d = 1'b1;
          end
        end
        DONE: begin
          if (ack) begin
            state_d    = IDLE;
            eop_ok_d   = 1'b0;
            line_err_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q     <= IDLE;
      bitcnt_q    <= '0;
      se0cnt_q    <= '0;
      rcv_valid_q <= 1'b0;
      rcv_start_q <= 1'b0;
      pkt_done_q  <= 1'b0;
      eop_ok_q    <= 1'b0;
      line_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      se0cnt_q    <= se0cnt_d;
      rcv_valid_q <= rcv_valid_d;
      rcv_start_q <= rcv_start_d;
      pkt_done_q  <= pkt_done_d;
      eop_ok_q    <= eop_ok_d;
      line_err_q  <= line_err_d;
    end
  end

  assign rcv_valid = rcv_valid_q;
  assign rcv_start = rcv_start_q;
  // SE0 already in the sync stage marks the bit now on stream_in as the last one.
  assign rcv_last  = rcv_valid_q && (state_q == ACTIVE) && (sync_st == SE0) && !sending;
  assign pkt_done  = pkt_done_q;
  assign EOP_ok    = eop_ok_q;
  assign line_err  = line_err_q;

endmodule

// File: tb/tb_usb_line_rcv.sv
// Scoreboard bench for usb_line_rcv: expected bits queued at drive time, popped on rcv_valid.
module tb_usb_line_rcv;

  localparam logic [1:0] LJ = 2'b10;
  localparam logic [1:0] LK = 2'b01;
  localparam logic [1:0] L0 = 2'b00;
  localparam logic [1:0] L1 = 2'b11;

  logic clk, rst_L, dp_in, dm_in, sending, ack;
  logic stream_in, rcv_valid, rcv_start, rcv_last, pkt_done, EOP_ok, line_err;

  typedef struct packed {
    logic s;
    logic st;
    logic ls;
  } exp_t;

  exp_t exp_q[$];
  bit   pkt_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0;
  int valid_cnt, done_cnt, stray_cnt, last_valid_cyc, done_cyc, done_valid;

  usb_line_rcv #(.MAX_BITS(128)) dut (
    .clk      (clk),
    .rst_L    (rst_L),
    .dp_in    (dp_in),
    .dm_in    (dm_in),
    .sending  (sending),
    .ack      (ack),
    .stream_in(stream_in),
    .rcv_valid(rcv_valid),
    .rcv_start(rcv_start),
    .rcv_last (rcv_last),
    .pkt_done (pkt_done),
    .EOP_ok   (EOP_ok),
    .line_err (line_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Output monitor: compares every delivered bit against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rcv_valid) begin
        if (exp_q.size() == 0) begin
          stray_cnt++;
        end else begin
          e = exp_q.pop_front();
          check_eq("stream", stream_in, e.s);
          check_eq("start", rcv_start, e.st);
          check_eq("last", rcv_last, e.ls);
        end
        valid_cnt++;
        last_valid_cyc = cyc;
      end else if (rcv_start || rcv_last) begin
        stray_cnt++;
      end
      if (pkt_done) begin
        done_cnt++;
        done_cyc   = cyc;
        done_valid = valid_cnt;
      end
    end
  end

  task automatic clr();
    valid_cnt      = 0;
    done_cnt       = 0;
    stray_cnt      = 0;
    last_valid_cyc = 0;
    done_cyc       = 0;
    done_valid     = 0;
  endtask

  task automatic drive(input logic [1:0] s, input int n);
    repeat (n) begin
      @(negedge clk);
      {dp_in, dm_in} = s;
    end
  endtask

  task automatic load_ack();
    logic [15:0] pat;
    pat = 16'b0101_0100_1101_1000;
    pkt_q.delete();
    for (int i = 0; i < 16; i++) pkt_q.push_back(pat[15-i]);
  endtask

  task automatic send_bits(input int n, input int n_exp, input bit mark_last, input int ack_at);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      {dp_in, dm_in} = pkt_q[i] ? LJ : LK;
      ack = (ack_at >= 0) && (i >= ack_at) && (i < ack_at + 3);
      if (i < n_exp)
        exp_q.push_back(exp_t'{s: pkt_q[i], st: (i == 0), ls: (mark_last && (i == n_exp - 1))});
    end
    ack = 1'b0;
  endtask

  task automatic expect_end(input string tag, input int nvalid, input int ndone,
                            input logic ok, input logic err);
    check_eq({tag, "_nvalid"}, valid_cnt, nvalid);
    check_eq({tag, "_ndone"}, done_cnt, ndone);
    check_eq({tag, "_qleft"}, exp_q.size(), 0);
    check_eq({tag, "_stray"}, stray_cnt, 0);
    check_eq({tag, "_eop_ok"}, EOP_ok, ok);
    check_eq({tag, "_line_err"}, line_err, err);
  endtask

  task automatic do_ack();
    @(negedge clk);
    ack = 1'b1;
    @(posedge clk);
    #1;
    check_eq("ack_eop_ok_clr", EOP_ok, 0);
    check_eq("ack_line_err_clr", line_err, 0);
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_stream"}, stream_in, 1);
    check_eq({tag, "_valid"}, rcv_valid, 0);
    check_eq({tag, "_start"}, rcv_start, 0);
    check_eq({tag, "_last"}, rcv_last, 0);
    check_eq({tag, "_done"}, pkt_done, 0);
    check_eq({tag, "_eop_ok"}, EOP_ok, 0);
    check_eq({tag, "_line_err"}, line_err, 0);
  endtask

  initial begin
    rst_L   = 1'b1;
    dp_in   = 1'b1;
    dm_in   = 1'b0;
    sending = 1'b0;
    ack     = 1'b0;
    clr();
    #2 rst_L = 1'b0;
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    @(negedge clk);
    rst_L = 1'b1;
    drive(LJ, 3);

    // ACK packet with a stray ack pulse while ACTIVE
    clr();
    load_ack();
    send_bits(16, 16, 1'b1, 4);
    drive(L0, 2);
    drive(LJ, 6);
    expect_end("ack", 16, 1, 1'b1, 1'b0);
    check_eq("ack_done_lat", done_cyc - last_valid_cyc, 3);
    do_ack();

    // EOP with a single SE0
    drive(LJ, 2);
    clr();
    load_ack();
    send_bits(16, 16, 1'b1, -1);
    drive(L0, 1);
    drive(LJ, 6);
    expect_end("eop1", 16, 1, 1'b0, 1'b1);
    do_ack();

    // EOP with three SE0
    drive(LJ, 2);
    clr();
    load_ack();
    send_bits(16, 16, 1'b1, -1);
    drive(L0, 3);
    drive(LJ, 6);
    expect_end("eop3", 16, 1, 1'b0, 1'b1);
    do_ack();

    // SE1 after five bits
    drive(LJ, 2);
    clr();
    load_ack();
    send_bits(5, 5, 1'b0, -1);
    drive(L1, 1);
    drive(LJ, 6);
    expect_end("se1", 5, 1, 1'b0, 1'b1);
    check_eq("se1_done_lat", done_cyc - last_valid_cyc, 1);
    do_ack();

    // Runaway: SYNC plus 200 alternating bits, no SE0
    drive(LJ, 2);
    clr();
    load_ack();
    while (pkt_q.size() > 8) void'(pkt_q.pop_back());
    for (int i = 0; i < 200; i++) pkt_q.push_back(i % 2 == 0);
    send_bits(208, 128, 1'b0, -1);
    drive(LJ, 6);
    expect_end("run", 128, 1, 1'b0, 1'b1);
    check_eq("run_done_at", done_valid, 128);
    check_eq("run_done_lat", done_cyc - last_valid_cyc, 1);
    do_ack();

    // Local transmit takes the bus after ten delivered bits
    drive(LJ, 2);
    clr();
    load_ack();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      {dp_in, dm_in} = pkt_q[i] ? LJ : LK;
      if (i < 10) exp_q.push_back(exp_t'{s: pkt_q[i], st: (i == 0), ls: 1'b0});
      if (i == 11) begin
        sending = 1'b1;
        @(posedge clk);
        #1;
        check_eq("snd_valid_drop", rcv_valid, 0);
      end
    end
    drive(L0, 2);
    drive(LJ, 1);
    @(negedge clk);
    sending = 1'b0;
    drive(LJ, 4);
    expect_end("snd", 10, 0, 1'b0, 1'b0);

    // Fresh packet after the transmit window
    clr();
    load_ack();
    send_bits(16, 16, 1'b1, -1);
    drive(L0, 2);
    drive(LJ, 6);
    expect_end("snd_next", 16, 1, 1'b1, 1'b0);
    do_ack();

    // Single-bit packet
    drive(LJ, 2);
    clr();
    pkt_q.delete();
    pkt_q.push_back(1'b0);
    send_bits(1, 1, 1'b1, -1);
    drive(L0, 2);
    drive(LJ, 6);
    expect_end("one", 1, 1, 1'b1, 1'b0);
    do_ack();

    // Reset mid-packet
    drive(LJ, 2);
    clr();
    load_ack();
    send_bits(8, 8, 1'b0, -1);
    @(posedge clk);
    #3;
    check_eq("mid_valid_before", rcv_valid, 1);
    rst_L = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    exp_q.delete();
    @(negedge clk);
    {dp_in, dm_in} = LJ;
    @(negedge clk);
    rst_L = 1'b1;
    drive(LJ, 4);
    check_eq("mid_rst_ndone", done_cnt, 0);
    check_eq("mid_rst_stray", stray_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_line_rcv.md
# usb_line_rcv

Receive-side line front end of the USB serial engine. It samples the bus DP/DM levels and detects start-of-packet on the first J→K transition. It delivers the raw NRZI line level, with framing strobes, to the NRZI decoder and bit unstuffer. It also checks EOP (SE0, SE0, J), guards against SE1 and runaway packets, and holds status until the packet decoder acknowledges.

## Interface
Parameters:
- MAX_BITS, 128: packet line bits (SYNC included) allowed before SE0; exceeding this is a runaway error.

Ports:
- clk  input  1  system clock, one bus bit per cycle
- rst_L  input  1  reset, asynchronous, active-low
- dp_in  input  1  sampled DP wire level
- dm_in  input  1  sampled DM wire level
- sending  input  1  local transmitter owns the bus; receiver ignores the line
- ack  input  1  decoder finished with the packet; re-arm
- stream_in  output  1  NRZI line level to the NRZI decoder (J=1, K=0)
- rcv_valid  output  1  stream_in carries a packet bit this cycle
- rcv_start  output  1  pulse with the first SYNC bit
- rcv_last  output  1  pulse with the final bit before SE0
- pkt_done  output  1  one-cycle pulse when the packet terminates, normally or in error
- EOP_ok  output  1  EOP was exactly SE0, SE0, J; held until ack
- line_err  output  1  SE1 seen, runaway, or bad EOP; held until ack

## Operation
- Line states: J = (dp,dm)=10, K = 01, SE0 = 00, SE1 = 11.
- Input register sync_q samples {dp_in, dm_in} every edge. Hold register hold_q takes sync_q every edge. stream_in = J/K value of hold_q.
- FSM states: IDLE, ARMED, ACTIVE, EOP, DONE.
- IDLE: wait for sync_q = J, then go to ARMED. This covers reset and bus-reset SE0.
- ARMED: sync_q = K → ACTIVE. At the same time load bitcnt = 1 and assert rcv_start/rcv_valid once that K reaches hold_q. SE0 or SE1 keeps the FSM in ARMED with no flags.
- ACTIVE: rcv_valid = 1 each cycle hold_q holds a packet bit. Per-condition behaviour:
  - sync_q = SE0: rcv_last = 1 combinationally with the current bit. Go to EOP with se0cnt = 1.
  - sync_q = SE1: line_err = 1, pkt_done = 1, go to DONE.
  - bitcnt reaches MAX_BITS: line_err = 1, pkt_done = 1, go to DONE.
- EOP: count consecutive SE0 in se0cnt (2-bit, saturating at 3). On the first non-SE0 sample:
  - EOP_ok = (sample is J) && (se0cnt == 2).
  - line_err = !EOP_ok.
  - pkt_done pulses; go to DONE.
- DONE: EOP_ok and line_err hold. ack → IDLE, clearing both. ack in any other state is ignored.
- sending = 1 in any state except DONE forces IDLE the next edge. No flags are raised, and rcv_valid drops immediately.
- bitcnt width is $clog2(MAX_BITS+1); it does not wrap.

## Timing
- Reset values:
  - stream_in = 1 (J).
  - rcv_valid, rcv_start, rcv_last, pkt_done, EOP_ok, line_err = 0.
  - FSM = IDLE; sync_q and hold_q = J.
- Latency: a bit sampled at edge t appears on stream_in after edge t+1, i.e. 2 cycles.
- rcv_start and rcv_valid rise in the same cycle. rcv_last coincides with the last rcv_valid cycle.
- pkt_done arrives 1 cycle after the J that follows SE0 is registered. EOP_ok and line_err become valid in that same cycle.
- ack is honoured on the first edge it is seen high in DONE. The next SOP is accepted only after J is seen again in IDLE.
- A 1-cycle SE0 in EOP followed by J gives EOP_ok = 0 and line_err = 1. Three or more SE0 gives the same result.
- A single-bit packet is legal framing: rcv_start, rcv_last and rcv_valid all fire in one cycle.
- rst_L low mid-packet clears everything asynchronously; no pkt_done.

## Structure
- Shared package usb_pkg holds:
  - line_state_t enum {J, K, SE0, SE1}
  - rx_state_t enum
  - helper function decoding {dp, dm} to line_state_t
  - constant EOP_SE0_BITS = 2
- One natural sub-module, usb_line_sampler: the sync_q/hold_q pipeline plus the line-state decode. The FSM and counters stay in usb_line_rcv.

## Test plan
- ACK packet: J idle, then K J K J K J K K, then J J K J J K K K, then SE0 SE0 J. Required response:
  - 16 rcv_valid cycles with stream_in = 0101_0100_1101_1000.
  - rcv_start on bit 1, rcv_last on bit 16.
  - pkt_done; EOP_ok = 1, line_err = 0 until ack.
- Bad EOP: same packet ending SE0 J, and separately SE0 SE0 SE0 J → EOP_ok = 0, line_err = 1, pkt_done once.
- SE1 mid-packet after 5 bits → line_err = 1 and pkt_done the cycle after detection; rcv_last never asserts.
- Runaway: SYNC followed by 200 alternating J/K with no SE0 → line_err at bitcnt = 128 and exactly 128 rcv_valid cycles.
- sending = 1 raised after 10 bits of a valid packet → rcv_valid drops next cycle, no pkt_done. A fresh packet after sending = 0 and J idle is received cleanly.
- Reset and ack checks:
  - rst_L pulsed low mid-packet → all outputs at reset values immediately.
  - ack asserted in ACTIVE has no effect.
  - ack in DONE clears EOP_ok the next cycle.
